// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the pipeline MEM stage and the data-memory responder.
interface data_mem_responder_if;
    // A request transfers on a rising edge with req_valid && req_ready; resp_valid is a
    // one-cycle pulse with no back-pressure, and resp_rdata/resp_err are qualified by it.
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per request and
// saturating load/store/error counters.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic [15:0]          err_count,
    output logic [1:0]           state_dbg
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    assign bus.req_ready = (state == IDLE) || (state == RESP);
    assign accept        = bus.req_valid && bus.req_ready;
    assign state_dbg     = state;

    // With zero wait states the access happens on the accepting edge, so it must use the
    // live request fields rather than the capture registers loaded on that same edge.
    always_comb begin
        acc_write  = cap_write;
        acc_addr   = cap_addr;
        acc_wdata  = cap_wdata;
        enter_resp = 1'b0;
        if (state == WAIT) begin
            enter_resp = (wait_cnt == 4'd1);
        end else if (accept && (WAIT_CYCLES == 0)) begin
            enter_resp = 1'b1;
            acc_write  = bus.req_write;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx = acc_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            cap_write      <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
            err_count      <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.resp_valid <= enter_resp;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;

            case (state)
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: begin
                    if (accept) begin
                        cap_write <= bus.req_write;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase

            // The store commits on the edge entering RESP, ahead of any later-accepted load.
            if (enter_resp) begin
                if (acc_err) begin
                    bus.resp_err <= 1'b1;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                end else if (acc_write) begin
                    mem[acc_idx] <= acc_wdata;
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    bus.resp_rdata <= mem[acc_idx];
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=0 and a WAIT_CYCLES=2 instance share clock and
// reset; an acceptance-ordered reference model feeds per-instance expected queues.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int EW    = 65;   // {response cycle[31:0], err, rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if b0 ();
    data_mem_responder_if b2 ();

    logic [15:0] rd_c [2];
    logic [15:0] wr_c [2];
    logic [15:0] er_c [2];
    logic [1:0]  st   [2];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave),
        .rd_count(rd_c[0]), .wr_count(wr_c[0]), .err_count(er_c[0]), .state_dbg(st[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave),
        .rd_count(rd_c[1]), .wr_count(wr_c[1]), .err_count(er_c[1]), .state_dbg(st[1])
    );

    // ---------------- reference model / scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [31:0]   ref_mem [2][DEPTH];
    int            ref_rd  [2];
    int            ref_wr  [2];
    int            ref_err [2];
    int            acc_e   [2];
    bit            acc_have[2];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] q_front(input int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    function automatic void q_push(input int d, input logic [EW-1:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic void q_pop(input int d);
        if (d == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endfunction

    function automatic void flush_model();
        exp_q0.delete();
        exp_q1.delete();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
            ref_rd[d]   = 0;
            ref_wr[d]   = 0;
            ref_err[d]  = 0;
            acc_have[d] = 1'b0;
            acc_e[d]    = 0;
        end
    endfunction

    // Called in the cycle before the accepting edge; requests take effect in acceptance order.
    function automatic void model_accept(input int d, input logic w, input logic [31:0] a,
                                         input logic [31:0] wd);
        logic        err;
        logic [31:0] rdata;
        int          e;
        err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        rdata = '0;
        if (err) begin
            ref_err[d]++;
        end else if (w) begin
            ref_mem[d][int'(a[31:2])] = wd;
            ref_wr[d]++;
        end else begin
            rdata = ref_mem[d][int'(a[31:2])];
            ref_rd[d]++;
        end
        e = cyc + 1 + wc(d);
        q_push(d, {e[31:0], err, rdata});
        acc_e[d]    = cyc + 1;
        acc_have[d] = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd);
        if (d == 0) begin
            b0.req_valid = v; b0.req_write = w; b0.req_addr = a; b0.req_wdata = wd;
        end else begin
            b2.req_valid = v; b2.req_write = w; b2.req_addr = a; b2.req_wdata = wd;
        end
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? b0.req_ready : b2.req_ready;
    endfunction

    // Leaves req_valid high on return so consecutive calls form a back-to-back stream.
    task automatic send(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        int waited;
        waited = 0;
        drive(d, 1'b1, w, a, wd);
        while (!get_ready(d)) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout d%0d: req_ready low for %0d cycles, expected within 50",
                         d, waited);
                idle(d);
                return;
            end
        end
        model_accept(d, w, a, wd);
        @(posedge clk); #1;
    endtask

    task automatic op(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        send(d, w, a, wd);
        idle(d);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        @(posedge clk); #1;
        flush_model();
        repeat (cycles - 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (q_size(d) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (q_size(d) != 0) begin
            n_fail++;
            $display("FAIL drain d%0d: %0d responses outstanding, expected 0", d, q_size(d));
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
    endtask

    task automatic check_cnt(input int d, input string tag);
        chk($sformatf("%s rd_count d%0d", tag, d),  {16'h0, rd_c[d]}, ref_rd[d]);
        chk($sformatf("%s wr_count d%0d", tag, d),  {16'h0, wr_c[d]}, ref_wr[d]);
        chk($sformatf("%s err_count d%0d", tag, d), {16'h0, er_c[d]}, ref_err[d]);
    endtask

    // ---------------- monitor ----------------
    task automatic check_outputs(input int d);
        logic [EW-1:0] e;
        logic          exp_ready;
        logic          rv;
        logic          re;
        logic [31:0]   rd;
        rv = (d == 0) ? b0.resp_valid : b2.resp_valid;
        re = (d == 0) ? b0.resp_err   : b2.resp_err;
        rd = (d == 0) ? b0.resp_rdata : b2.resp_rdata;
        exp_ready = !(acc_have[d] && cyc >= acc_e[d] && cyc < acc_e[d] + wc(d));
        chk($sformatf("req_ready d%0d cyc%0d", d, cyc), 32'(get_ready(d)), 32'(exp_ready));
        e = (q_size(d) != 0) ? q_front(d) : '0;
        if (q_size(d) != 0 && e[64:33] == cyc[31:0]) begin
            q_pop(d);
            chk($sformatf("resp_valid d%0d cyc%0d", d, cyc), 32'(rv), 32'd1);
            chk($sformatf("resp_rdata d%0d cyc%0d", d, cyc), rd, e[31:0]);
            chk($sformatf("resp_err d%0d cyc%0d", d, cyc), 32'(re), 32'(e[32]));
        end else begin
            chk($sformatf("resp_valid_idle d%0d cyc%0d", d, cyc), 32'(rv), 32'd0);
            chk($sformatf("resp_idle_zero d%0d cyc%0d", d, cyc), {rd[31:1], rd[0] | re}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_outputs(d);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          d;
        int          len;
        rst = 1'b1;
        idle(0);
        idle(1);

        // Reset with a request pending on both instances: nothing may be accepted.
        drive(0, 1'b1, 1'b1, 32'h10, 32'hAAAA_AAAA);
        drive(1, 1'b1, 1'b1, 32'h10, 32'hAAAA_AAAA);
        do_reset(2);
        idle(0);
        idle(1);
        check_cnt(0, "reset");
        check_cnt(1, "reset");
        op(1, 1'b0, 32'h10, 32'h0);
        drain(1);

        // Store then load accepted in the store's response cycle.
        do_reset(1);
        send(1, 1'b1, 32'h08, 32'hDEAD_BEEF);
        send(1, 1'b0, 32'h08, 32'h0);
        idle(1);
        drain(1);
        check_cnt(1, "st_ld");

        // Four back-to-back loads.
        for (int i = 0; i < 4; i++) send(1, 1'b0, 32'(i * 4), 32'h0);
        idle(1);
        drain(1);

        // Misaligned load, out-of-range store, then word 0x3F read back.
        do_reset(1);
        op(1, 1'b0, 32'h06, 32'h0);
        op(1, 1'b1, 32'(4 * DEPTH), 32'h5555_5555);
        op(1, 1'b0, 32'hFC, 32'h0);
        drain(1);
        check_cnt(1, "errors");

        // Reset in the first WAIT cycle of a store.
        do_reset(1);
        send(1, 1'b1, 32'h04, 32'h1234_5678);
        idle(1);
        do_reset(1);
        op(1, 1'b0, 32'h04, 32'h0);
        drain(1);
        check_cnt(1, "mid_reset");

        // Zero-wait instance: three consecutive stores, then one read back.
        do_reset(1);
        send(0, 1'b1, 32'h00, 32'h1111_0001);
        send(0, 1'b1, 32'h04, 32'h2222_0002);
        send(0, 1'b1, 32'h08, 32'h3333_0003);
        idle(0);
        drain(0);
        check_cnt(0, "wait0");
        op(0, 1'b0, 32'h04, 32'h0);
        drain(0);

        // Randomised bursts over both instances.
        for (int it = 0; it < 150; it++) begin
            d   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                a = 32'($urandom_range(0, DEPTH + 3)) * 32'd4;
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) a = $urandom;
                send(d, 1'($urandom_range(0, 1)), a, $urandom);
            end
            idle(d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain(0);
        drain(1);
        check_cnt(0, "final");
        check_cnt(1, "final");

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
